multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Sequencing control unit for the multi-cycle RV32I datapath. It is the issuing end of the ALU interface: it decodes the latched instruction, drives the 4-bit ALU operation code and the operand-select muxes, and consumes the ALU `zero` flag for branch resolution. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. A ready handshake stalls it on a slow memory.

## Interface
Parameters:
- `INSTR_WIDTH`, 32: instruction width.
- `ALUCONTROL_WIDTH`, 4: ALU operation code width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction register contents.
- `zero`  in  1  ALU result-equals-zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `MemWrite`  out  1  store strobe; valid only with `mem_req`.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU output register.
- `IRWrite`  out  1  load the instruction register and OldPC.
- `PCWrite`  out  1  load the PC from the result mux.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result select: 0 = ALU output register, 1 = data register, 2 = live ALU result.
- `ALUSrcA`  out  2  operand A select: 0 = PC, 1 = OldPC, 2 = rs1.
- `ALUSrcB`  out  2  operand B select: 0 = rs2, 1 = immediate, 2 = constant 4.
- `ImmSrc`  out  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = J.
- `ALUControl`  out  4  ALU operation code.
- `illegal_instr`  out  1  sticky illegal-instruction flag; present only when `ILLEGAL_TRAP_EN` is defined.

## Operation
- ALU codes: ADD 0x0, SUB 0x1, AND 0x2, OR 0x3, XOR 0x4, SLT 0x5, SHL 0x6, SHR 0x7, SGTE 0x8, EQ 0x9, NE 0xA.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- FETCH:
  - Drives `mem_req`=1, `AdrSrc`=0, ALU = PC + 4.
  - Holds until `mem_ready`=1. In that cycle it pulses `IRWrite` and `PCWrite`, then moves to DECODE.
- DECODE: computes OldPC + B-immediate (branch target, held in the ALU output register). Dispatches on opcode:
  - 0000011 → MEMADR (load)
  - 0100011 → MEMADR (store)
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
- MEMADR: computes rs1 + immediate (I format for loads, S format for stores). Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD / MEMWRITE: `mem_req`=1, `AdrSrc`=1; MEMWRITE also drives `MemWrite`=1. Both hold until `mem_ready`. MEMREAD then goes to MEMWB; MEMWRITE goes to FETCH.
- MEMWB: `ResultSrc`=1, `RegWrite`=1, then FETCH.
- EXECR / EXECI: ALU op from funct3, then ALUWB.
  - funct3 mapping: 000 ADD, 001 SHL, 010 SLT, 100 XOR, 101 SHR, 110 OR, 111 AND.
  - In EXECR only, funct3=000 with funct7[5]=1 selects SUB.
  - Any other funct3 or funct7 pattern is illegal.
- ALUWB: `ResultSrc`=0, `RegWrite`=1, then FETCH.
- BRANCH: compares rs1 with rs2. The ALU result is not written; `ResultSrc`=0 selects the target computed in DECODE.

  | funct3 | ALU op | `PCWrite` when |
  |---|---|---|
  | 000 (beq) | SUB | `zero`=1 |
  | 001 (bne) | SUB | `zero`=0 |
  | 100 (blt) | SLT | `zero`=0 |
  | 101 (bge) | SGTE | `zero`=0 |

  Other funct3 values are illegal. BRANCH then goes to FETCH.
- JAL:
  - Computes OldPC + J-immediate with `ResultSrc`=2 and `PCWrite`=1.
  - The ALU output register captures OldPC + 4 computed in DECODE for the J-type path: when the opcode is 1101111, DECODE instead drives A=OldPC, B=4.
  - Next state is ALUWB, which writes rd.
- x0 suppression is the register file's job, not this block's.

## Timing
- Latency in cycles, with `mem_ready` held high: R/I-type 4, load 5, store 4, branch 3, jal 4.
- Each cycle `mem_ready` is low adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Outputs are pure Moore decode of the state, except three `mem_ready`/`zero`-qualified terms:
  - FETCH `IRWrite` and `PCWrite`, qualified by `mem_ready`.
  - BRANCH `PCWrite`, qualified by `zero`.
  - MEMREAD/MEMWRITE exit, qualified by `mem_ready`.
- During reset, and in the first cycle after it:
  - State is FETCH.
  - `mem_req`, `MemWrite`, `IRWrite`, `PCWrite` and `RegWrite` are 0, `illegal_instr` is 0, and all selects are 0.
  - `ALUControl` is ADD.
- FETCH starts requesting on the first edge after `rst_n` rises.
- Reset asserted mid-access aborts immediately with no writes. The memory side must tolerate a dropped request.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An unknown opcode or illegal funct in DECODE, EXECR, EXECI or BRANCH enters TRAP.
  - TRAP holds all strobes low and sets `illegal_instr`=1 until reset.
- `ILLEGAL_TRAP_EN` undefined:
  - Illegal encodings return to FETCH with no register or memory write; the PC has already advanced.
  - The TRAP state and the `illegal_instr` port are absent.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU op codes.
  - Opcode constants.
  - The state enum.
  - `ResultSrc`, `ALUSrcA`, `ALUSrcB` and `ImmSrc` encodings.
- The ALU must import the same codes.
- Sub-module `alu_op_decode`: combinational mapping of {state, funct3, funct7[5]} to `ALUControl` plus an illegal flag. The FSM lives in the top.

## Test plan
- add x3,x1,x2 (0x002081B3), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB; `ALUControl`=0x0 in EXECR; `RegWrite`=1 in cycle 4 only.
- sub (0x402081B3) → `ALUControl`=0x1 in EXECR.
- lw with `mem_ready` low for 3 cycles in MEMREAD → `mem_req`=1 and `AdrSrc`=1 held for 4 cycles, total latency 8, a single `RegWrite` pulse with `ResultSrc`=1.
- beq: `zero`=1 → `PCWrite`=1 in BRANCH with `ResultSrc`=0; `zero`=0 → `PCWrite`=0.
- bge: `ALUControl`=0x8; `zero`=0 → taken.
- Opcode 0x7F:
  - With `ILLEGAL_TRAP_EN` → TRAP, `illegal_instr`=1, no strobes until reset.
  - Without it → back to FETCH with no write.
- `rst_n` low in MEMWRITE while waiting on `mem_ready` → `MemWrite`=0 immediately; FETCH after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: ALU op codes, opcodes, FSM states and mux selects.
// ILLEGAL_TRAP_EN adds the TRAP state used by the illegal-instruction trap.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SHL  = 4'h6,
        ALU_SHR  = 4'h7,
        ALU_SGTE = 4'h8,
        ALU_EQ   = 4'h9,
        ALU_NE   = 4'hA
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
        , ST_TRAP   = 4'd11
`endif
    } state_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_DATA   = 2'd1,
        RES_ALU    = 2'd2
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3
    } imm_src_t;

    // beq takes on equality; bne/blt/bge all take when the ALU result is non-zero.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return (funct3 == 3'b000) ? zero : !zero;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode from {state, funct3, funct7[5]}, with an
// illegal flag for encodings the datapath does not implement.
module alu_op_decode
    import riscv_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_op,
    output logic       illegal
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (state)
            ST_EXECR, ST_EXECI: begin
                case (funct3)
                    3'b000:  alu_op = (state == ST_EXECR && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SHL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = ALU_SHR;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: illegal = 1'b1;
                endcase
                // In I-type only the shift immediates carry a funct7 field.
                if (state == ST_EXECR && funct7_b5 && funct3 != 3'b000)
                    illegal = 1'b1;
                if (state == ST_EXECI && funct7_b5 && (funct3 == 3'b001 || funct3 == 3'b101))
                    illegal = 1'b1;
            end
            ST_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100:         alu_op = ALU_SLT;
                    3'b101:         alu_op = ALU_SGTE;
                    default:        illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing FSM: fetch/decode/execute/memory/writeback with
// memory ready stall. Define ILLEGAL_TRAP_EN for a sticky TRAP on illegal encodings.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int INSTR_WIDTH      = 32,
    parameter int ALUCONTROL_WIDTH = 4
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INSTR_WIDTH-1:0]      instr,
    input  logic                        zero,
    input  logic                        mem_ready,
    output logic                        mem_req,
    output logic                        MemWrite,
    output logic                        AdrSrc,
    output logic                        IRWrite,
    output logic                        PCWrite,
    output logic                        RegWrite,
    output logic [1:0]                  ResultSrc,
    output logic [1:0]                  ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic [2:0]                  ImmSrc,
    output logic [ALUCONTROL_WIDTH-1:0] ALUControl
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                        illegal_instr
`endif
);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ST_ILLEGAL = ST_TRAP;
`else
    localparam state_t ST_ILLEGAL = ST_FETCH;
`endif

    state_t     state;
    state_t     state_next;
    logic       run;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_load;
    logic [3:0] dec_op;
    logic       funct_illegal;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_b5         = instr[30];
    assign is_load           = (opcode == OP_LOAD);
    assign unused_instr_bits = ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

    alu_op_decode u_alu_op_decode (
        .state     (state),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_op    (dec_op),
        .illegal   (funct_illegal)
    );

    // run stays low through reset and the first cycle after it, keeping every output idle.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (run) begin
            case (state)
                ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                        OP_RTYPE:          state_next = ST_EXECR;
                        OP_ITYPE:          state_next = ST_EXECI;
                        OP_BRANCH:         state_next = ST_BRANCH;
                        OP_JAL:            state_next = ST_JAL;
                        default:           state_next = ST_ILLEGAL;
                    endcase
                end
                ST_MEMADR:   state_next = is_load ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD:  if (mem_ready) state_next = ST_MEMWB;
                ST_MEMWRITE: if (mem_ready) state_next = ST_FETCH;
                ST_MEMWB:    state_next = ST_FETCH;
                ST_EXECR,
                ST_EXECI:    state_next = funct_illegal ? ST_ILLEGAL : ST_ALUWB;
                ST_ALUWB:    state_next = ST_FETCH;
                ST_BRANCH:   state_next = funct_illegal ? ST_ILLEGAL : ST_FETCH;
                ST_JAL:      state_next = ST_ALUWB;
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP:     state_next = ST_TRAP;
`endif
                default:     state_next = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALUCONTROL_WIDTH'(ALU_ADD);
        if (run) begin
            case (state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    ResultSrc = RES_ALU;
                    ALUSrcB   = SRCB_FOUR;
                end
                ST_DECODE: begin
                    // JAL needs OldPC + 4 in the ALU output register instead of the branch target.
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = (opcode == OP_JAL) ? SRCB_FOUR : SRCB_IMM;
                    ImmSrc  = IMM_B;
                end
                ST_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = is_load ? IMM_I : IMM_S;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                ST_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                ST_EXECR: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ALUControl = ALUCONTROL_WIDTH'(dec_op);
                end
                ST_EXECI: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_I;
                    ALUControl = ALUCONTROL_WIDTH'(dec_op);
                end
                ST_ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ImmSrc     = IMM_B;
                    ResultSrc  = RES_ALUOUT;
                    ALUControl = ALUCONTROL_WIDTH'(dec_op);
                    PCWrite    = branch_taken(funct3, zero) && !funct_illegal;
                end
                ST_JAL: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_IMM;
                    ImmSrc    = IMM_J;
                    ResultSrc = RES_ALU;
                    PCWrite   = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand-written
// illegal-instruction and reset-abort sequences. Honours ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    multicycle_ctrl #(.INSTR_WIDTH(32), .ALUCONTROL_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_instr (illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
    logic [18:0] obs;
    assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    typedef struct {
        logic        r;
        logic [31:0] instr;
        logic        z;
        logic        m;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BGE  = 32'h0020D463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_BBAD = 32'h0020A463;

    function automatic logic [18:0] o(input logic req, mw, adr, irw, pcw, rw,
                                      input logic [1:0] rs, a, b,
                                      input logic [2:0] imm, input logic [3:0] alu);
        return {req, mw, adr, irw, pcw, rw, rs, a, b, imm, alu};
    endfunction

    logic [18:0] e_idle, e_fwait, e_fgo, e_dec, e_decj, e_exadd, e_exsub, e_exi, e_wb;
    logic [18:0] e_mald, e_mast, e_mrd, e_mwr, e_mwb, e_beq_t, e_beq_n, e_bge_t, e_jal, e_bbad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic z, input logic m,
                        input logic [18:0] e, input string name);
        @(posedge clk);
        #1;
        rst_n     = r;
        instr     = i;
        zero      = z;
        mem_ready = m;
        #3;
        check(name, 32'(obs), 32'(e));
    endtask

    task automatic add_vec(input logic r, input logic [31:0] i, input logic z, input logic m,
                           input logic [18:0] e);
        vecs.push_back('{r: r, instr: i, z: z, m: m, exp: e});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        e_idle  = o(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'h0);
        e_fwait = o(1,0,0,0,0,0, 2'd2,2'd0,2'd2, 3'd0, 4'h0);
        e_fgo   = o(1,0,0,1,1,0, 2'd2,2'd0,2'd2, 3'd0, 4'h0);
        e_dec   = o(0,0,0,0,0,0, 2'd0,2'd1,2'd1, 3'd2, 4'h0);
        e_decj  = o(0,0,0,0,0,0, 2'd0,2'd1,2'd2, 3'd2, 4'h0);
        e_exadd = o(0,0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd0, 4'h0);
        e_exsub = o(0,0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd0, 4'h1);
        e_exi   = o(0,0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, 4'h0);
        e_wb    = o(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0, 4'h0);
        e_mald  = o(0,0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, 4'h0);
        e_mast  = o(0,0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd1, 4'h0);
        e_mrd   = o(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'h0);
        e_mwr   = o(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'h0);
        e_mwb   = o(0,0,0,0,0,1, 2'd1,2'd0,2'd0, 3'd0, 4'h0);
        e_beq_t = o(0,0,0,0,1,0, 2'd0,2'd2,2'd0, 3'd2, 4'h1);
        e_beq_n = o(0,0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd2, 4'h1);
        e_bge_t = o(0,0,0,0,1,0, 2'd0,2'd2,2'd0, 3'd2, 4'h8);
        e_jal   = o(0,0,0,0,1,0, 2'd2,2'd1,2'd1, 3'd3, 4'h0);
        e_bbad  = o(0,0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd2, 4'h0);

        // reset, then the first cycle after release: everything idle
        add_vec(0, I_ADD, 0, 1, e_idle);
        add_vec(1, I_ADD, 0, 1, e_idle);
        // add: FETCH DECODE EXECR ALUWB
        add_vec(1, I_ADD, 0, 1, e_fgo);
        add_vec(1, I_ADD, 0, 1, e_dec);
        add_vec(1, I_ADD, 0, 1, e_exadd);
        add_vec(1, I_ADD, 0, 1, e_wb);
        // sub with one fetch stall
        add_vec(1, I_SUB, 0, 0, e_fwait);
        add_vec(1, I_SUB, 0, 1, e_fgo);
        add_vec(1, I_SUB, 0, 1, e_dec);
        add_vec(1, I_SUB, 0, 1, e_exsub);
        add_vec(1, I_SUB, 0, 1, e_wb);
        // lw with three MEMREAD stall cycles: 8 cycles total
        add_vec(1, I_LW, 0, 1, e_fgo);
        add_vec(1, I_LW, 0, 1, e_dec);
        add_vec(1, I_LW, 0, 1, e_mald);
        add_vec(1, I_LW, 0, 0, e_mrd);
        add_vec(1, I_LW, 0, 0, e_mrd);
        add_vec(1, I_LW, 0, 0, e_mrd);
        add_vec(1, I_LW, 0, 1, e_mrd);
        add_vec(1, I_LW, 0, 1, e_mwb);
        // sw, no stall
        add_vec(1, I_SW, 0, 1, e_fgo);
        add_vec(1, I_SW, 0, 1, e_dec);
        add_vec(1, I_SW, 0, 1, e_mast);
        add_vec(1, I_SW, 0, 1, e_mwr);
        // beq taken, beq not taken, bge taken
        add_vec(1, I_BEQ, 0, 1, e_fgo);
        add_vec(1, I_BEQ, 0, 1, e_dec);
        add_vec(1, I_BEQ, 1, 1, e_beq_t);
        add_vec(1, I_BEQ, 0, 1, e_fgo);
        add_vec(1, I_BEQ, 0, 1, e_dec);
        add_vec(1, I_BEQ, 0, 1, e_beq_n);
        add_vec(1, I_BGE, 0, 1, e_fgo);
        add_vec(1, I_BGE, 0, 1, e_dec);
        add_vec(1, I_BGE, 0, 1, e_bge_t);
        // jal: DECODE uses A=OldPC B=4, then JAL, then ALUWB
        add_vec(1, I_JAL, 0, 1, e_fgo);
        add_vec(1, I_JAL, 0, 1, e_decj);
        add_vec(1, I_JAL, 0, 1, e_jal);
        add_vec(1, I_JAL, 0, 1, e_wb);
        // addi
        add_vec(1, I_ADDI, 0, 1, e_fgo);
        add_vec(1, I_ADDI, 0, 1, e_dec);
        add_vec(1, I_ADDI, 0, 1, e_exi);
        add_vec(1, I_ADDI, 0, 1, e_wb);

        for (int k = 0; k < vecs.size(); k++)
            step(vecs[k].r, vecs[k].instr, vecs[k].z, vecs[k].m, vecs[k].exp,
                 $sformatf("vec%0d", k));

        // unknown opcode 0x7F
        step(1, I_BAD, 0, 1, e_fgo, "bad_fetch");
        step(1, I_BAD, 0, 1, e_dec, "bad_decode");
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            step(1, I_BAD, 1, 1, e_idle, $sformatf("trap_strobes%0d", k));
            check($sformatf("trap_flag%0d", k), 32'(illegal_instr), 32'd1);
        end
        step(0, I_BAD, 0, 1, e_idle, "trap_reset");
        check("trap_flag_cleared", 32'(illegal_instr), 32'd0);
        step(1, I_BAD, 0, 1, e_idle, "trap_release");
`else
        step(1, I_BAD, 0, 0, e_fwait, "bad_back_to_fetch");
        // illegal R-type funct3 (sltu): EXECR, then straight back to FETCH
        step(1, I_SLTU, 0, 1, e_fgo, "sltu_fetch");
        step(1, I_SLTU, 0, 1, e_dec, "sltu_decode");
        step(1, I_SLTU, 0, 1, e_exadd, "sltu_exec");
        step(1, I_SLTU, 0, 0, e_fwait, "sltu_no_wb");
        // illegal branch funct3: no PC write even with zero=1
        step(1, I_BBAD, 0, 1, e_fgo, "bbad_fetch");
        step(1, I_BBAD, 0, 1, e_dec, "bbad_decode");
        step(1, I_BBAD, 1, 1, e_bbad, "bbad_branch");
        step(1, I_BBAD, 0, 0, e_fwait, "bbad_back_to_fetch");
`endif

        // reset while MEMWRITE waits on mem_ready
        step(1, I_SW, 0, 1, e_fgo, "rst_sw_fetch");
        step(1, I_SW, 0, 1, e_dec, "rst_sw_decode");
        step(1, I_SW, 0, 1, e_mast, "rst_sw_memadr");
        step(1, I_SW, 0, 0, e_mwr, "rst_sw_wait0");
        step(1, I_SW, 0, 0, e_mwr, "rst_sw_wait1");
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_abort_memwrite", 32'(MemWrite), 32'd0);
        check("rst_abort_memreq", 32'(mem_req), 32'd0);
        check("rst_abort_all", 32'(obs), 32'(e_idle));
        step(0, I_SW, 0, 1, e_idle, "rst_held");
        step(1, I_SW, 0, 1, e_idle, "rst_first_cycle");
        step(1, I_SW, 0, 0, e_fwait, "rst_fetch_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
